// File: rtl/fetch_queue.sv
// fetch_queue: instruction buffer between fetch and decode.
// Holds {pc+4, instruction} pairs delivered on cache hits in a small circular
// FIFO, presents the oldest entry to decode, stalls fetch when full and drops
// everything on a taken branch. Also counts fetch miss cycles (saturating).
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hit_in,
  input  logic [31:0]   addr_in,
  input  logic [31:0]   instruction_in,
  input  logic          flush,
  input  logic          ready_in,
  output logic          fetch_stall,
  output logic          valid_out,
  output logic [31:0]   addr_out,
  output logic [31:0]   instruction_out,
  output logic [AW:0]   count_out,
  output logic [CW-1:0] miss_count
);

  localparam logic [AW:0]   CountFull = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);
  localparam logic [CW-1:0] MissMax   = {CW{1'b1}};
  localparam logic [CW-1:0] MissOne   = CW'(1);

  // Entry storage: upper half is pc+4, lower half is the instruction word.
  logic [63:0]   mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [CW-1:0] miss_q,   miss_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Status flags come straight from registered state so decode and fetch
  // never see a combinational path from this cycle's inputs.
  always_comb begin
    full        = (count_q == CountFull);
    valid_out   = (count_q != '0);
    fetch_stall = full;
    count_out   = count_q;
    miss_count  = miss_q;
  end

  // Handshake decode. A full queue refuses a push even if decode pops in the
  // same cycle (fetch is already holding its PC), and a flush kills both.
  always_comb begin
    push = hit_in & ~full & ~flush;
    pop  = valid_out & ready_in & ~flush;
  end

  // Next-state for pointers and occupancy; flush restarts both pointers at 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CountOne;
        2'b01:   count_d = count_q - CountOne;
        default: count_d = count_q;
      endcase
    end
  end

  // Miss statistic: counts cycles fetch had nothing to offer, ignoring flush
  // cycles, and sticks at its maximum rather than wrapping.
  always_comb begin
    miss_d = miss_q;
    if (!hit_in && !flush && (miss_q != MissMax)) begin
      miss_d = miss_q + MissOne;
    end
  end

  // Control state register; reset may arrive at any point in a stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      miss_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      miss_q   <= miss_d;
    end
  end

  // Entry write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {addr_in, instruction_in};
    end
  end

  // Head presentation: an empty queue shows address 0 and a NOP word.
  always_comb begin
    head            = mem_q[rd_ptr_q];
    addr_out        = valid_out ? head[63:32] : 32'h0;
    instruction_out = valid_out ? head[31:0]  : 32'h0;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a scoreboard of
// expected head entries checked by a monitor whenever decode pops.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 4;

  logic          clk;
  logic          reset;
  logic          hit_in;
  logic [31:0]   addr_in;
  logic [31:0]   instruction_in;
  logic          flush;
  logic          ready_in;
  logic          fetch_stall;
  logic          valid_out;
  logic [31:0]   addr_out;
  logic [31:0]   instruction_out;
  logic [AW:0]   count_out;
  logic [CW-1:0] miss_count;

  int            total;
  int            bad;
  logic [63:0]   sb [$];

  fetch_queue #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .hit_in          (hit_in),
    .addr_in         (addr_in),
    .instruction_in  (instruction_in),
    .flush           (flush),
    .ready_in        (ready_in),
    .fetch_stall     (fetch_stall),
    .valid_out       (valid_out),
    .addr_out        (addr_out),
    .instruction_out (instruction_out),
    .count_out       (count_out),
    .miss_count      (miss_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of fetch/decode activity. When acc is set the word is
  // known (by hand) to be accepted and is queued as an expected head entry.
  task automatic applyStimulus(input logic hit, input logic [31:0] addr,
                               input logic [31:0] instr, input logic rdy,
                               input logic fl, input logic acc);
    hit_in         = hit;
    addr_in        = addr;
    instruction_in = instr;
    ready_in       = rdy;
    flush          = fl;
    if (fl) sb.delete();
    if (acc) sb.push_back({addr, instr});
    @(posedge clk);
    #1;
  endtask

  // Monitor: on every cycle decode takes the head, it must be the oldest
  // expected entry.
  task automatic monitorLoop();
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && valid_out && ready_in && !flush) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL pop_unexpected: got %0h expected none",
                   {addr_out, instruction_out});
        end else begin
          exp = sb.pop_front();
          checkOutput("pop_head", {addr_out, instruction_out}, exp);
        end
      end
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    hit_in         = 1'b0;
    addr_in        = 32'h0;
    instruction_in = 32'h0;
    flush          = 1'b0;
    ready_in       = 1'b0;
    fork
      monitorLoop();
    join_none

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(valid_out), 64'd0);
    checkOutput("rst_count", 64'(count_out), 64'd0);
    checkOutput("rst_stall", 64'(fetch_stall), 64'd0);
    checkOutput("rst_addr", 64'(addr_out), 64'd0);
    checkOutput("rst_instr", 64'(instruction_out), 64'd0);
    checkOutput("rst_miss", 64'(miss_count), 64'd0);
    reset = 1'b0;

    // Fill with decode stalled, then offer a fifth word that must be refused.
    $display("[TB] fill to full");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * (i + 1)), 32'hAAAA_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
      checkOutput("fill_stall", 64'(fetch_stall), (i == 3) ? 64'd1 : 64'd0);
    end
    applyStimulus(1'b1, 32'd20, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    checkOutput("full_count", 64'(count_out), 64'd4);
    checkOutput("full_stall", 64'(fetch_stall), 64'd1);
    checkOutput("full_head", {addr_out, instruction_out}, {32'd4, 32'hAAAA_0000});

    // Drain from full while fetch keeps offering; the first offer is refused
    // and re-presented, after which push and pop overlap across the wrap.
    $display("[TB] drain with overlap");
    applyStimulus(1'b1, 32'd20, 32'hBBBB_0000, 1'b1, 1'b0, 1'b0);
    checkOutput("first_pop_count", 64'(count_out), 64'd3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'(20 + 4 * i), 32'hBBBB_0000 + 32'(i), 1'b1, 1'b0, 1'b1);
      checkOutput("overlap_count", 64'(count_out), 64'd3);
    end

    // Bring occupancy to 2, then flush alongside a hit and a ready.
    $display("[TB] flush");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_flush_count", 64'(count_out), 64'd2);
    applyStimulus(1'b1, 32'h99, 32'hCCCC_FFFF, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_count", 64'(count_out), 64'd0);
    checkOutput("flush_valid", 64'(valid_out), 64'd0);
    checkOutput("flush_head", {addr_out, instruction_out}, 64'd0);
    applyStimulus(1'b1, 32'h100, 32'hCCCC_0000, 1'b0, 1'b0, 1'b1);
    checkOutput("post_flush_valid", 64'(valid_out), 64'd1);
    checkOutput("post_flush_head", {addr_out, instruction_out}, {32'h100, 32'hCCCC_0000});
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_drain", 64'(count_out), 64'd0);

    // Miss counter: three misses then a hit, then saturation.
    $display("[TB] miss counter");
    reset = 1'b1;
    sb.delete();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h200, 32'hD000_0000, 1'b0, 1'b0, 1'b1);
    checkOutput("miss_three", 64'(miss_count), 64'd3);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("miss_sat", 64'(miss_count), 64'd15);

    // Reset mid-stream with three entries held; outputs clear immediately.
    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h300 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
    checkOutput("pre_rst_count", 64'(count_out), 64'd3);
    reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("mid_rst_valid", 64'(valid_out), 64'd0);
    checkOutput("mid_rst_count", 64'(count_out), 64'd0);
    checkOutput("mid_rst_stall", 64'(fetch_stall), 64'd0);
    checkOutput("mid_rst_instr", 64'(instruction_out), 64'd0);
    checkOutput("mid_rst_miss", 64'(miss_count), 64'd0);
    #1;
    reset = 1'b0;

    // Steady push+pop at occupancy 1: each word heads the queue one cycle
    // after it was offered.
    $display("[TB] steady stream");
    applyStimulus(1'b1, 32'h400, 32'hF000_0000, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 32'h400 + 32'(4 * i), 32'hF000_0000 + 32'(i), 1'b1, 1'b0, 1'b1);
      checkOutput("stream_count", 64'(count_out), 64'd1);
      checkOutput("stream_head", {addr_out, instruction_out},
                  {32'h400 + 32'(4 * i), 32'hF000_0000 + 32'(i)});
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("end_count", 64'(count_out), 64'd0);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
